// File: rtl/gpr_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
// Build option: GPR_FILE_BYPASS_EN (same-cycle write-to-read forwarding).
package gpr_pkg;

  localparam int GPR_DATA_W     = 16;
  localparam int GPR_ADDR_W     = 3;
  // Widest data bus the response struct can carry; DATA_W must not exceed it.
  localparam int GPR_DATA_W_MAX = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } gpr_state_e;

  // Registered read response of one port; data is zero-extended to the max width.
  typedef struct packed {
    logic                      rvalid;
    logic [GPR_DATA_W_MAX-1:0] data;
  } gpr_rsp_t;

endpackage

// File: rtl/gpr_rd_port.sv
// One read port: request acceptance, optional write bypass, response register.
// Build option: GPR_FILE_BYPASS_EN forwards a same-cycle write to the same address.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_en,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] data
);

  logic              fire;
  logic [DATA_W-1:0] rd_val;
  gpr_rsp_t          rsp_q;

  assign ready = accept_en;
  assign fire  = valid && accept_en;

`ifdef GPR_FILE_BYPASS_EN
  // Forward the write data when the accepted read hits the address being written.
  always_comb begin
    rd_val = regs[addr];
    if (wr_fire && (wr_addr == addr)) rd_val = wr_data;
  end
`else
  assign rd_val = regs[addr];
  logic unused_wr;
  assign unused_wr = ^{wr_fire, wr_addr, wr_data};
`endif

  // Response register: rvalid pulses once per accepted request, data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.rvalid <= fire;
      if (fire) rsp_q.data <= GPR_DATA_W_MAX'(rd_val);
    end
  end

  assign rvalid = rsp_q.rvalid;
  assign data   = rsp_q.data[DATA_W-1:0];

  logic unused_rsp;
  assign unused_rsp = ^rsp_q.data;

endmodule

// File: rtl/gpr_file_2r1w.sv
// General-purpose register file: two registered read ports, one write port,
// and a sequential clear that zeroes one entry per cycle.
// Build option: GPR_FILE_BYPASS_EN (read returns same-cycle write data).
//
// Read handshake: a request transfers on a rising edge where valid and ready
// are both high; the response (rvalid pulse + data) appears in the following
// cycle. ready is high whenever no clear is running, so there is no back-pressure
// in ST_IDLE and every request is refused during ST_CLEAR.
module gpr_file_2r1w
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rda_valid,
  input  logic [ADDR_W-1:0] rda_addr,
  output logic              rda_ready,
  output logic              rda_rvalid,
  output logic [DATA_W-1:0] rda_data,
  input  logic              rdb_valid,
  input  logic [ADDR_W-1:0] rdb_addr,
  output logic              rdb_ready,
  output logic              rdb_rvalid,
  output logic [DATA_W-1:0] rdb_data,
  input  logic              clr_req,
  output logic              busy,
  output gpr_state_e        fsm_state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  gpr_state_e        state, state_nxt;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              idle;
  logic              wr_fire;

  assign idle      = (state == ST_IDLE);
  assign wr_fire   = wr_en && idle;
  assign busy      = (state == ST_CLEAR);
  assign fsm_state = state;

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: start a clear from idle, leave after the last entry is zeroed.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt   = ST_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Storage: clear has priority; writes only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == ST_CLEAR) begin
      regs[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  gpr_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept_en (idle),
    .valid     (rda_valid),
    .addr      (rda_addr),
    .regs      (regs),
    .wr_fire   (wr_fire),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ready     (rda_ready),
    .rvalid    (rda_rvalid),
    .data      (rda_data)
  );

  gpr_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept_en (idle),
    .valid     (rdb_valid),
    .addr      (rdb_addr),
    .regs      (regs),
    .wr_fire   (wr_fire),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ready     (rdb_ready),
    .rvalid    (rdb_rvalid),
    .data      (rdb_data)
  );

endmodule
